// File: rtl/y_check_pkg.sv
// Shared types and constants for the y-bus response checker.
// Holds the checker FSM state encoding, the default MISR polynomial and seed,
// and the helper that sizes the fold (number of SIG_W words covering y).
package y_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEFAULT_SEED = 32'hFFFF_FFFF;

  // Number of SIG_W-bit words needed to cover a y_w-bit bus (ceiling division).
  function automatic int unsigned fold_word_count(input int unsigned y_w,
                                                  input int unsigned sig_w);
    return (y_w + sig_w - 1) / sig_w;
  endfunction

endpackage

// File: rtl/y_misr.sv
// Multiple-input signature register for one response channel.
// Each enabled cycle the signature is shifted through the POLY feedback and
// XORed with the fold of y (all SIG_W words of y XORed together, y zero-padded
// at the MSB end). load_i reloads SEED and takes priority over en_i.
// sig_next_o exposes the value the register takes on the coming edge so the
// parent can register a verdict in the same cycle the final sample lands.
module y_misr
  import y_check_pkg::*;
#(
  parameter int unsigned          Y_W   = 258,
  parameter int unsigned          SIG_W = 32,
  parameter logic [SIG_W-1:0]     POLY  = DEFAULT_POLY,
  parameter logic [SIG_W-1:0]     SEED  = DEFAULT_SEED
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Y_W-1:0]   y_i,
  output logic [SIG_W-1:0] sig_o,
  output logic [SIG_W-1:0] sig_next_o
);

  localparam int unsigned N_WORDS = fold_word_count(Y_W, SIG_W);
  localparam int unsigned PAD_W   = N_WORDS * SIG_W;

  logic [PAD_W-1:0] y_pad;
  logic [SIG_W-1:0] fold_w;
  logic [SIG_W-1:0] step_w;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Zero-pad y to a whole number of words, then XOR the words together.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    y_pad           = '0;
    y_pad[Y_W-1:0]  = y_i;
    fold_w          = '0;
    for (int w = 0; w < int'(N_WORDS); w++) begin
      fold_w = fold_w ^ y_pad[w*SIG_W +: SIG_W];
    end
  end

  // Galois-style shift with polynomial feedback, then pick seed / step / hold.
  always_comb begin
    step_w = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0);
    if (load_i) begin
      sig_d = SEED;
    end else if (en_i) begin
      sig_d = step_w ^ fold_w;
    end else begin
      sig_d = sig_q;
    end
  end

  // Signature register with synchronous reset to zero.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst_i) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o      = sig_q;
  assign sig_next_o = sig_d;

endmodule

// File: rtl/y_response_checker.sv
// Equivalence checker for the fuzzed `top` output bus y.
// Compacts the reference (y_a) and netlist (y_b) streams into two MISR
// signatures over N_CYCLES valid samples, tracks the first mismatching
// sample index and registers a pass/fail verdict on entry to DONE.
// Optional build macro: Y_DIFF_CAPTURE_EN adds diff_vec_o, the XOR of the
// first mismatching pair of samples.
module y_response_checker
  import y_check_pkg::*;
#(
  parameter int unsigned      Y_W      = 258,
  parameter int unsigned      SIG_W    = 32,
  parameter logic [SIG_W-1:0] POLY     = DEFAULT_POLY,
  parameter logic [SIG_W-1:0] SEED     = DEFAULT_SEED,
  parameter int unsigned      N_CYCLES = 20,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             y_valid_i,
  input  logic [Y_W-1:0]   y_a_i,
  input  logic [Y_W-1:0]   y_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [SIG_W-1:0] sig_a_o,
  output logic [SIG_W-1:0] sig_b_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] first_diff_cycle_o,
  output logic             diff_seen_o
`ifdef Y_DIFF_CAPTURE_EN
  ,
  output logic [Y_W-1:0]   diff_vec_o
`endif
);

  // Reject configurations where the sample counter could wrap or be empty.
  if (N_CYCLES == 0 || 64'(N_CYCLES) >= (64'd1 << CNT_W)) begin : g_cfg_error
    $error("y_response_checker: N_CYCLES must satisfy 1 <= N_CYCLES < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] first_diff_q, first_diff_d;
  logic             diff_seen_q, diff_seen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             misr_load;
  logic             misr_en;
  logic             capture;
  logic [SIG_W-1:0] sig_a_next, sig_b_next;

  // Next-state, counter and verdict logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d      = state_q;
    cycle_cnt_d  = cycle_cnt_q;
    first_diff_d = first_diff_q;
    diff_seen_d  = diff_seen_q;
    misr_load    = 1'b0;
    misr_en      = 1'b0;
    capture      = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        // A sample presented together with start is not consumed.
        if (start_i) begin
          state_d      = RUN;
          misr_load    = 1'b1;
          cycle_cnt_d  = '0;
          first_diff_d = '0;
          diff_seen_d  = 1'b0;
        end
      end
      RUN: begin
        if (y_valid_i) begin
          misr_en     = 1'b1;
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
          if ((y_a_i != y_b_i) && !diff_seen_q) begin
            first_diff_d = cycle_cnt_q;
            diff_seen_d  = 1'b1;
            capture      = 1'b1;
          end
          if (cycle_cnt_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Status flops are loaded from the next state so they line up with it.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (sig_a_next == sig_b_next) && !diff_seen_d;
  end

  // FSM, counters and status registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cycle_cnt_q  <= '0;
      first_diff_q <= '0;
      diff_seen_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycle_cnt_q  <= cycle_cnt_d;
      first_diff_q <= first_diff_d;
      diff_seen_q  <= diff_seen_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  y_misr #(
    .Y_W  (Y_W),
    .SIG_W(SIG_W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr_a (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (misr_load),
    .en_i      (misr_en),
    .y_i       (y_a_i),
    .sig_o     (sig_a_o),
    .sig_next_o(sig_a_next)
  );

  y_misr #(
    .Y_W  (Y_W),
    .SIG_W(SIG_W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr_b (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (misr_load),
    .en_i      (misr_en),
    .y_i       (y_b_i),
    .sig_o     (sig_b_o),
    .sig_next_o(sig_b_next)
  );

`ifdef Y_DIFF_CAPTURE_EN
  logic [Y_W-1:0] diff_vec_q;

  // Capture the XOR of the first mismatching pair; clear on start or reset.
  always_ff @(posedge clk_i) begin
    // NOTE: this is a plain register, not a memory, so it is reset like any
    // other flop; only true RAM arrays are left unreset.
    if (rst_i || misr_load) begin
      diff_vec_q <= '0;
    end else if (capture) begin
      diff_vec_q <= y_a_i ^ y_b_i;
    end
  end

  assign diff_vec_o = diff_vec_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign pass_o             = pass_q;
  assign cycle_cnt_o        = cycle_cnt_q;
  assign first_diff_cycle_o = first_diff_q;
  assign diff_seen_o        = diff_seen_q;

endmodule

// File: tb/tb_y_response_checker.sv
// Directed testbench for y_response_checker.
// Two instances share the sample bus: u_dut1 (N_CYCLES=1) for the single-sample
// fold vector and u_dut20 (N_CYCLES=20) for full runs. Expected signatures come
// from a bit-serial fold model kept in the bench.
module tb_y_response_checker;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start1, start20, y_valid;
  logic [257:0] y_a, y_b;

  logic        busy1, done1, pass1, ds1;
  logic [31:0] sa1, sb1;
  logic [15:0] cnt1, fd1;
  logic        busy20, done20, pass20, ds20;
  logic [31:0] sa20, sb20;
  logic [15:0] cnt20, fd20;
`ifdef Y_DIFF_CAPTURE_EN
  logic [257:0] dv1, dv20;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side reference model state for u_dut20.
  logic [31:0]  exp_sa, exp_sb, clean_sig;
  logic [15:0]  exp_cnt, exp_first;
  logic         exp_seen;
  logic [257:0] exp_dv;

  y_response_checker #(.N_CYCLES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .y_valid_i(y_valid),
    .y_a_i(y_a), .y_b_i(y_b), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .sig_a_o(sa1), .sig_b_o(sb1), .cycle_cnt_o(cnt1),
    .first_diff_cycle_o(fd1), .diff_seen_o(ds1)
`ifdef Y_DIFF_CAPTURE_EN
    , .diff_vec_o(dv1)
`endif
  );

  y_response_checker #(.N_CYCLES(20)) u_dut20 (
    .clk_i(clk), .rst_i(rst), .start_i(start20), .y_valid_i(y_valid),
    .y_a_i(y_a), .y_b_i(y_b), .busy_o(busy20), .done_o(done20), .pass_o(pass20),
    .sig_a_o(sa20), .sig_b_o(sb20), .cycle_cnt_o(cnt20),
    .first_diff_cycle_o(fd20), .diff_seen_o(ds20)
`ifdef Y_DIFF_CAPTURE_EN
    , .diff_vec_o(dv20)
`endif
  );

  // Reference MISR step: fold bit i of y into signature bit i mod 32.
  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [257:0] y);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < 258; i++) f[i % 32] = f[i % 32] ^ y[i];
    return ({s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0)) ^ f;
  endfunction

  // Deterministic pseudo-random sample for index idx.
  function automatic logic [257:0] gen_y(input int idx);
    logic [287:0] t;
    for (int w = 0; w < 9; w++)
      t[w*32 +: 32] = 32'(32'h9E3779B9 * 32'(idx * 9 + w + 1)) ^ 32'h5A5A_0F0F;
    return t[257:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run();
    start20 = 1'b1; y_valid = 1'b0;
    tick();
    start20 = 1'b0;
    exp_sa = SEED; exp_sb = SEED; exp_cnt = '0; exp_first = '0; exp_seen = 1'b0; exp_dv = '0;
  endtask

  // Present one valid sample for one clock and advance the model.
  task automatic feed(input logic [257:0] a, input logic [257:0] b);
    y_a = a; y_b = b; y_valid = 1'b1;
    tick();
    y_valid = 1'b0;
    exp_sa = ref_step(exp_sa, a);
    exp_sb = ref_step(exp_sb, b);
    if (a != b && !exp_seen) begin
      exp_first = exp_cnt; exp_seen = 1'b1; exp_dv = a ^ b;
    end
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b1; start20 = 1'b1; y_valid = 1'b1;
    y_a = gen_y(0); y_b = gen_y(1);
    tick();
    rst = 1'b0; start1 = 1'b0; start20 = 1'b0; y_valid = 1'b0;
    if (busy20 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy20); end n_checks++;
    if (done20 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done20); end n_checks++;
    if (pass20 !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b want 0", pass20); end n_checks++;
    if (sa20 !== 32'h0 || sb20 !== 32'h0) begin n_fail++; $display("FAIL reset_sig: got %h/%h want 0/0", sa20, sb20); end n_checks++;
    if (cnt20 !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt20); end n_checks++;
    if (fd20 !== 16'h0 || ds20 !== 1'b0) begin n_fail++; $display("FAIL reset_diff: got fd=%0d ds=%b want 0/0", fd20, ds20); end n_checks++;
    if (busy1 !== 1'b0 || sa1 !== 32'h0) begin n_fail++; $display("FAIL reset_dut1: got busy=%b sig=%h want 0/0", busy1, sa1); end n_checks++;
`ifdef Y_DIFF_CAPTURE_EN
    if (dv20 !== '0) begin n_fail++; $display("FAIL reset_diff_vec: got %h want 0", dv20); end n_checks++;
`endif
  endtask

  task automatic test_single_fold();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin n_fail++; $display("FAIL fold_start: got busy=%b done=%b want 1/0", busy1, done1); end n_checks++;
    if (sa1 !== SEED) begin n_fail++; $display("FAIL fold_seed: got %h want %h", sa1, SEED); end n_checks++;
    y_a = 258'd1; y_b = 258'd1; y_valid = 1'b1;
    tick();
    y_valid = 1'b0;
    if (sa1 !== 32'hFB3EE248 || sb1 !== 32'hFB3EE248) begin n_fail++; $display("FAIL fold_sig: got %h/%h want fb3ee248", sa1, sb1); end n_checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL fold_done: got done=%b busy=%b want 1/0", done1, busy1); end n_checks++;
    if (pass1 !== 1'b1 || cnt1 !== 16'd1) begin n_fail++; $display("FAIL fold_pass: got pass=%b cnt=%0d want 1/1", pass1, cnt1); end n_checks++;
  endtask

  task automatic test_clean();
    begin_run();
    for (int k = 0; k < 20; k++) begin
      feed(gen_y(k), gen_y(k));
      if (k == 18) begin
        if (done20 !== 1'b0 || cnt20 !== 16'd19) begin n_fail++; $display("FAIL clean_early: got done=%b cnt=%0d want 0/19", done20, cnt20); end n_checks++;
      end
    end
    clean_sig = exp_sa;
    if (done20 !== 1'b1 || busy20 !== 1'b0) begin n_fail++; $display("FAIL clean_done: got done=%b busy=%b want 1/0", done20, busy20); end n_checks++;
    if (cnt20 !== 16'd20) begin n_fail++; $display("FAIL clean_cnt: got %0d want 20", cnt20); end n_checks++;
    if (pass20 !== 1'b1 || ds20 !== 1'b0) begin n_fail++; $display("FAIL clean_pass: got pass=%b ds=%b want 1/0", pass20, ds20); end n_checks++;
    if (sa20 !== exp_sa || sb20 !== exp_sb) begin n_fail++; $display("FAIL clean_sig: got %h/%h want %h/%h", sa20, sb20, exp_sa, exp_sb); end n_checks++;
    // DONE ignores further samples.
    y_a = gen_y(40); y_b = gen_y(41); y_valid = 1'b1;
    tick(); tick();
    y_valid = 1'b0;
    if (sa20 !== clean_sig || cnt20 !== 16'd20 || done20 !== 1'b1) begin n_fail++; $display("FAIL done_hold: got sig=%h cnt=%0d done=%b want %h/20/1", sa20, cnt20, done20, clean_sig); end n_checks++;
  endtask

  task automatic test_single_fault();
    logic [257:0] b;
    begin_run();
    for (int k = 0; k < 20; k++) begin
      b = gen_y(k);
      if (k == 7) b[257] = ~b[257];
      feed(gen_y(k), b);
    end
    if (ds20 !== 1'b1 || fd20 !== 16'd7) begin n_fail++; $display("FAIL fault1_first: got ds=%b fd=%0d want 1/7", ds20, fd20); end n_checks++;
    if (pass20 !== 1'b0 || done20 !== 1'b1) begin n_fail++; $display("FAIL fault1_pass: got pass=%b done=%b want 0/1", pass20, done20); end n_checks++;
    if (sa20 !== exp_sa || sb20 !== exp_sb || sa20 === sb20) begin n_fail++; $display("FAIL fault1_sig: got %h/%h want %h/%h", sa20, sb20, exp_sa, exp_sb); end n_checks++;
`ifdef Y_DIFF_CAPTURE_EN
    if (dv20 !== (258'd1 << 257)) begin n_fail++; $display("FAIL fault1_diff_vec: got %h want %h", dv20, 258'd1 << 257); end n_checks++;
`endif
  endtask

  task automatic test_multi_fault();
    logic [257:0] b;
    begin_run();
    for (int k = 0; k < 20; k++) begin
      b = gen_y(k);
      if (k == 3)  b[0]   = ~b[0];
      if (k == 11) b[100] = ~b[100];
      feed(gen_y(k), b);
      if (k == 11) begin
        if (fd20 !== 16'd3 || ds20 !== 1'b1) begin n_fail++; $display("FAIL fault2_mid: got fd=%0d ds=%b want 3/1", fd20, ds20); end n_checks++;
      end
    end
    if (fd20 !== 16'd3 || pass20 !== 1'b0) begin n_fail++; $display("FAIL fault2_end: got fd=%0d pass=%b want 3/0", fd20, pass20); end n_checks++;
    if (sa20 !== exp_sa || sb20 !== exp_sb) begin n_fail++; $display("FAIL fault2_sig: got %h/%h want %h/%h", sa20, sb20, exp_sa, exp_sb); end n_checks++;
`ifdef Y_DIFF_CAPTURE_EN
    if (dv20 !== 258'd1) begin n_fail++; $display("FAIL fault2_diff_vec: got %h want 1", dv20); end n_checks++;
`endif
  endtask

  task automatic test_gaps();
    begin_run();
`ifdef Y_DIFF_CAPTURE_EN
    if (dv20 !== '0) begin n_fail++; $display("FAIL gaps_diff_vec_clear: got %h want 0", dv20); end n_checks++;
`endif
    for (int k = 0; k < 20; k++) begin
      if (k == 5) start20 = 1'b1;
      feed(gen_y(k), gen_y(k));
      start20 = 1'b0;
      if (k == 5) begin
        if (cnt20 !== 16'd6 || busy20 !== 1'b1) begin n_fail++; $display("FAIL gaps_start_ignored: got cnt=%0d busy=%b want 6/1", cnt20, busy20); end n_checks++;
      end
      y_a = gen_y(k + 100); y_b = gen_y(k + 200);
      tick(); tick();
      if (k == 5) begin
        if (cnt20 !== 16'd6 || sa20 !== exp_sa) begin n_fail++; $display("FAIL gaps_hold: got cnt=%0d sig=%h want 6/%h", cnt20, sa20, exp_sa); end n_checks++;
      end
    end
    if (sa20 !== clean_sig || sb20 !== clean_sig) begin n_fail++; $display("FAIL gaps_sig: got %h/%h want %h", sa20, sb20, clean_sig); end n_checks++;
    if (cnt20 !== 16'd20 || pass20 !== 1'b1) begin n_fail++; $display("FAIL gaps_end: got cnt=%0d pass=%b want 20/1", cnt20, pass20); end n_checks++;
  endtask

  task automatic test_reset_midrun();
    // start together with a mismatching valid sample: initialise only.
    start20 = 1'b1; y_valid = 1'b1; y_a = gen_y(0); y_b = gen_y(5);
    tick();
    start20 = 1'b0; y_valid = 1'b0;
    if (cnt20 !== 16'd0 || sa20 !== SEED || ds20 !== 1'b0) begin n_fail++; $display("FAIL start_valid: got cnt=%0d sig=%h ds=%b want 0/%h/0", cnt20, sa20, ds20, SEED); end n_checks++;
    for (int k = 0; k < 10; k++) feed(gen_y(k), gen_y(k));
    rst = 1'b1; start20 = 1'b1; y_valid = 1'b1;
    tick();
    rst = 1'b0; start20 = 1'b0; y_valid = 1'b0;
    if (busy20 !== 1'b0 || done20 !== 1'b0 || pass20 !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got busy=%b done=%b pass=%b want 0/0/0", busy20, done20, pass20); end n_checks++;
    if (sa20 !== 32'h0 || sb20 !== 32'h0 || cnt20 !== 16'h0) begin n_fail++; $display("FAIL midrst_state: got %h/%h cnt=%0d want 0/0/0", sa20, sb20, cnt20); end n_checks++;
    tick();
    if (busy20 !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got busy=%b want 0", busy20); end n_checks++;
    begin_run();
    for (int k = 0; k < 20; k++) feed(gen_y(k), gen_y(k));
    if (pass20 !== 1'b1 || cnt20 !== 16'd20 || done20 !== 1'b1) begin n_fail++; $display("FAIL restart_end: got pass=%b cnt=%0d done=%b want 1/20/1", pass20, cnt20, done20); end n_checks++;
    if (sa20 !== clean_sig || sb20 !== clean_sig) begin n_fail++; $display("FAIL restart_sig: got %h/%h want %h", sa20, sb20, clean_sig); end n_checks++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start1 = 1'b0; start20 = 1'b0; y_valid = 1'b0;
    y_a = '0; y_b = '0;
    test_reset();
    test_single_fold();
    test_clean();
    test_single_fault();
    test_multi_fault();
    test_gaps();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
